// File: rtl/watch_mode_ctrl.sv
// watch_mode_ctrl: debounces the three watch buttons and sequences the watch
// modes (time display, time set, stopwatch), producing the display state code,
// the stopwatch run/clear controls and the hour/minute increment pulses.
module watch_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 32,
  parameter int SET_TIMEOUT     = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       btn_ss,
  input  logic       sec_tick,
  output logic [2:0] state,
  output logic       sw_run,
  output logic       sw_clear,
  output logic       inc_h,
  output logic       inc_m
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam int REP_W  = $clog2(REPEAT_CYCLES) + 1;
  localparam int IDLE_W = $clog2(SET_TIMEOUT) + 1;

  // Mode codes as seen by the display block. The state register itself is a
  // plain 3-bit vector so that the unused code 111 is representable and can be
  // recovered from.
  typedef enum logic [2:0] {
    HIDE_STOPPED = 3'b000,
    SET_H        = 3'b001,
    SET_M        = 3'b010,
    SHOW_STOPPED = 3'b011,
    SHOW_RUNNING = 3'b100,
    SW_RESET     = 3'b101,
    HIDE_RUNNING = 3'b110
  } state_t;

  // Button index: 0 = mode, 1 = set, 2 = ss
  logic [2:0] btn_raw;
  logic [2:0] db;
  logic [2:0] press;

  assign btn_raw = {btn_ss, btn_set, btn_mode};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic            sync1_reg;
      logic            sync2_reg;
      logic            db_reg;
      logic            db_dly_reg;
      logic [DB_W-1:0] db_cnt_reg;

      // Synchronize the raw button, then accept a new level only after it has
      // differed from the debounced level for DEBOUNCE_CYCLES cycles in a row.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync1_reg  <= 1'b0;
          sync2_reg  <= 1'b0;
          db_reg     <= 1'b0;
          db_dly_reg <= 1'b0;
          db_cnt_reg <= '0;
        end else begin
          sync1_reg  <= btn_raw[gi];
          sync2_reg  <= sync1_reg;
          db_dly_reg <= db_reg;
          if (sync2_reg != db_reg) begin
            if (db_cnt_reg >= DB_W'(DEBOUNCE_CYCLES - 1)) begin
              db_reg     <= sync2_reg;
              db_cnt_reg <= '0;
            end else begin
              db_cnt_reg <= db_cnt_reg + 1'b1;
            end
          end else begin
            db_cnt_reg <= '0;
          end
        end
      end

      assign db[gi]    = db_reg;
      assign press[gi] = db_reg & ~db_dly_reg;
    end
  endgenerate

  logic [2:0]        state_reg, state_next;
  logic              sw_run_reg, sw_run_next;
  logic              sw_clear_reg, sw_clear_next;
  logic              inc_h_reg, inc_h_next;
  logic              inc_m_reg, inc_m_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic [REP_W-1:0]  rep_reg, rep_next;
  logic [IDLE_W-1:0] idle_reg, idle_next;

  logic       ev_mode, ev_set, ev_ss, any_ev;
  logic       in_set, next_in_set, timeout, repeat_pulse;
  logic [2:0] exit_state;

  // Mode state, stopwatch run level, output pulses and the set-mode counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= HIDE_STOPPED;
      sw_run_reg   <= 1'b0;
      sw_clear_reg <= 1'b0;
      inc_h_reg    <= 1'b0;
      inc_m_reg    <= 1'b0;
      hold_reg     <= '0;
      rep_reg      <= '0;
      idle_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      sw_run_reg   <= sw_run_next;
      sw_clear_reg <= sw_clear_next;
      inc_h_reg    <= inc_h_next;
      inc_m_reg    <= inc_m_next;
      hold_reg     <= hold_next;
      rep_reg      <= rep_next;
      idle_reg     <= idle_next;
    end
  end

  // Next-state logic: prioritized button events, set-mode timeout,
  // auto-repeat of the increment pulse and the idle-second counter.
  always_comb begin
    state_next    = state_reg;
    sw_run_next   = sw_run_reg;
    sw_clear_next = 1'b0;
    inc_h_next    = 1'b0;
    inc_m_next    = 1'b0;
    hold_next     = '0;
    rep_next      = '0;
    idle_next     = '0;
    repeat_pulse  = 1'b0;

    // Only the highest-priority event of a cycle is acted on.
    ev_mode    = press[0];
    ev_set     = press[1] & ~press[0];
    ev_ss      = press[2] & ~press[1] & ~press[0];
    any_ev     = |press;
    in_set     = (state_reg == SET_H) || (state_reg == SET_M);
    timeout    = in_set && !any_ev && (idle_reg >= IDLE_W'(SET_TIMEOUT));
    exit_state = sw_run_reg ? HIDE_RUNNING : HIDE_STOPPED;

    case (state_reg)
      HIDE_STOPPED: begin
        if (ev_mode)     state_next = SHOW_STOPPED;
        else if (ev_set) state_next = SET_H;
      end
      HIDE_RUNNING: begin
        if (ev_mode)     state_next = SHOW_RUNNING;
        else if (ev_set) state_next = SET_H;
      end
      SET_H: begin
        if (ev_set)       state_next = SET_M;
        else if (ev_ss)   inc_h_next = 1'b1;
        else if (timeout) state_next = exit_state;
      end
      SET_M: begin
        if (ev_set)       state_next = exit_state;
        else if (ev_ss)   inc_m_next = 1'b1;
        else if (timeout) state_next = exit_state;
      end
      SHOW_STOPPED: begin
        if (ev_mode) begin
          state_next = HIDE_STOPPED;
        end else if (ev_set) begin
          state_next    = SW_RESET;
          sw_clear_next = 1'b1;
        end else if (ev_ss) begin
          state_next  = SHOW_RUNNING;
          sw_run_next = 1'b1;
        end
      end
      SHOW_RUNNING: begin
        if (ev_mode) begin
          state_next = HIDE_RUNNING;
        end else if (ev_ss) begin
          state_next  = SHOW_STOPPED;
          sw_run_next = 1'b0;
        end
      end
      SW_RESET: begin
        if (ev_mode) begin
          state_next = HIDE_STOPPED;
        end else if (ev_ss) begin
          state_next  = SHOW_RUNNING;
          sw_run_next = 1'b1;
        end
      end
      default: state_next = HIDE_STOPPED;
    endcase

    // Auto-repeat: the hold counter saturates at HOLD_CYCLES (first repeat),
    // after which the repeat counter paces further pulses. Any state change
    // or ss release restarts both.
    if (in_set && db[2] && (state_next == state_reg)) begin
      if (hold_reg < HOLD_W'(HOLD_CYCLES)) begin
        hold_next = hold_reg + 1'b1;
      end else begin
        hold_next = hold_reg;
      end
      if (hold_reg == HOLD_W'(HOLD_CYCLES - 1)) begin
        repeat_pulse = 1'b1;
      end
      if (hold_reg == HOLD_W'(HOLD_CYCLES)) begin
        if (rep_reg >= REP_W'(REPEAT_CYCLES - 1)) begin
          rep_next     = '0;
          repeat_pulse = 1'b1;
        end else begin
          rep_next = rep_reg + 1'b1;
        end
      end
    end

    if (repeat_pulse) begin
      if (state_reg == SET_H) inc_h_next = 1'b1;
      else                    inc_m_next = 1'b1;
    end

    // Idle seconds only accumulate while a set mode is stable and untouched.
    next_in_set = (state_next == SET_H) || (state_next == SET_M);
    if (next_in_set && (state_next == state_reg) && !(|db) && !any_ev) begin
      if (sec_tick && (idle_reg < IDLE_W'(SET_TIMEOUT))) begin
        idle_next = idle_reg + 1'b1;
      end else begin
        idle_next = idle_reg;
      end
    end
  end

  assign state    = state_reg;
  assign sw_run   = sw_run_reg;
  assign sw_clear = sw_clear_reg;
  assign inc_h    = inc_h_reg;
  assign inc_m    = inc_m_reg;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// tb_watch_mode_ctrl: directed stimulus for watch_mode_ctrl. Each stimulus
// pushes its expected output event (and cycle, when known) into a queue; a
// monitor pops and compares whenever the DUT outputs change or pulse.
module tb_watch_mode_ctrl;

  localparam int D   = 16;
  localparam int H   = 64;
  localparam int R   = 32;
  localparam int T   = 10;
  localparam int LAT = D + 3;

  localparam logic [2:0] B_MODE = 3'b001;
  localparam logic [2:0] B_SET  = 3'b010;
  localparam logic [2:0] B_SS   = 3'b100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_set = 1'b0;
  logic       btn_ss = 1'b0;
  logic       sec_tick = 1'b0;
  logic [2:0] state;
  logic       sw_run, sw_clear, inc_h, inc_m;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [6:0] obs;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] prev_sr = 4'b0;
  logic [6:0] mon_obs;
  exp_t       mon_e;
  int         n0;

  watch_mode_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R),
    .SET_TIMEOUT(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_mode(btn_mode),
    .btn_set(btn_set),
    .btn_ss(btn_ss),
    .sec_tick(sec_tick),
    .state(state),
    .sw_run(sw_run),
    .sw_clear(sw_clear),
    .inc_h(inc_h),
    .inc_m(inc_m)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Packs an observation as {state, sw_run, sw_clear, inc_h, inc_m}.
  function automatic logic [6:0] mk(input logic [2:0] s, input logic r,
                                    input logic c, input logic h, input logic m);
    return {s, r, c, h, m};
  endfunction

  task automatic expect_at(input logic [6:0] o, input int at);
    exp_t e;
    e.obs = o;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b required %b at cycle %0d", name, got, want, cyc);
    end else begin
      $display("ok   %s: %b at cycle %0d", name, got, cyc);
    end
  endtask

  // Hold the given buttons long enough for a press, then release and let the
  // debounced levels fall again.
  task automatic press(input logic [2:0] b, input bit want, input logic [6:0] o);
    @(negedge clk);
    if (want) expect_at(o, cyc + LAT);
    {btn_ss, btn_set, btn_mode} = b;
    repeat (22) @(negedge clk);
    {btn_ss, btn_set, btn_mode} = 3'b000;
    repeat (22) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
    sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Monitor: an output event is a change of state/sw_run or any pulse high.
  always @(negedge clk) begin
    mon_obs = {state, sw_run, sw_clear, inc_h, inc_m};
    if (({state, sw_run} != prev_sr) || sw_clear || inc_h || inc_m) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got %b at cycle %0d required no output", mon_obs, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if ((mon_obs !== mon_e.obs) || ((mon_e.cyc >= 0) && (mon_e.cyc != cyc))) begin
          bad++;
          $display("FAIL output_event: got %b at cycle %0d required %b at cycle %0d",
                   mon_obs, cyc, mon_e.obs, mon_e.cyc);
        end else begin
          $display("ok   output_event: %b at cycle %0d", mon_obs, cyc);
        end
      end
    end
    prev_sr = {state, sw_run};
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {state, sw_run, sw_clear, inc_h, inc_m}, 7'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("after_release", {state, sw_run, sw_clear, inc_h, inc_m}, 7'b0);

    // Debounce rejection: short bursts must not register
    btn_mode = 1'b1; repeat (10) @(negedge clk);
    btn_mode = 1'b0; repeat (2) @(negedge clk);
    btn_mode = 1'b1; repeat (10) @(negedge clk);
    btn_mode = 1'b0; repeat (2) @(negedge clk);
    check("debounce_reject", {4'b0, state}, 7'b0);
    expect_at(mk(3'b011, 1'b0, 1'b0, 1'b0, 1'b0), cyc + LAT);
    btn_mode = 1'b1; repeat (25) @(negedge clk);
    btn_mode = 1'b0; repeat (22) @(negedge clk);

    // Stopwatch flow
    press(B_SS,   1'b1, mk(3'b100, 1'b1, 1'b0, 1'b0, 1'b0));
    press(B_MODE, 1'b1, mk(3'b110, 1'b1, 1'b0, 1'b0, 1'b0));
    press(B_SET,  1'b1, mk(3'b001, 1'b1, 1'b0, 1'b0, 1'b0));
    press(B_SET,  1'b1, mk(3'b010, 1'b1, 1'b0, 1'b0, 1'b0));
    press(B_SET,  1'b1, mk(3'b110, 1'b1, 1'b0, 1'b0, 1'b0));

    // Clear sequence
    press(B_MODE, 1'b1, mk(3'b100, 1'b1, 1'b0, 1'b0, 1'b0));
    press(B_SET,  1'b0, 7'b0);
    press(B_SS,   1'b1, mk(3'b011, 1'b0, 1'b0, 1'b0, 1'b0));
    press(B_SET,  1'b1, mk(3'b101, 1'b0, 1'b1, 1'b0, 1'b0));
    press(B_SET,  1'b0, 7'b0);
    press(B_SS,   1'b1, mk(3'b100, 1'b1, 1'b0, 1'b0, 1'b0));
    press(B_SS,   1'b1, mk(3'b011, 1'b0, 1'b0, 1'b0, 1'b0));
    press(B_MODE, 1'b1, mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0));

    // Auto-repeat in SET_H: db rises at n0+18, press pulse at n0+19,
    // repeats at n0+18+H, then every R.
    press(B_SET, 1'b1, mk(3'b001, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    n0 = cyc;
    expect_at(mk(3'b001, 1'b0, 1'b0, 1'b1, 1'b0), n0 + LAT);
    for (int k = 0; k < 4; k++) begin
      expect_at(mk(3'b001, 1'b0, 1'b0, 1'b1, 1'b0), n0 + 18 + H + k * R);
    end
    btn_ss = 1'b1;
    repeat (18 + H + 3 * R) @(negedge clk);
    btn_ss = 1'b0;
    repeat (40) @(negedge clk);

    // Timeout from SET_M with sw_run = 0
    press(B_SET, 1'b1, mk(3'b010, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < T - 1; k++) tick();
    check("timeout_not_early", {4'b0, state}, 7'b0000010);
    expect_at(mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0), -1);
    tick();
    repeat (5) @(negedge clk);
    check("timeout_exit", {4'b0, state}, 7'b0);

    // Priority: mode and set together in HIDE_STOPPED
    press(B_MODE | B_SET, 1'b1, mk(3'b011, 1'b0, 1'b0, 1'b0, 1'b0));
    press(B_SS, 1'b1, mk(3'b100, 1'b1, 1'b0, 1'b0, 1'b0));

    // Asynchronous reset while running
    @(posedge clk);
    #2;
    expect_at(mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0), -1);
    reset = 1'b0;
    #1;
    check("async_reset", {state, sw_run, sw_clear, inc_h, inc_m}, 7'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);

    // Illegal state recovery
    press(B_MODE, 1'b1, mk(3'b011, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    #2;
    force dut.state_reg = 3'b111;
    #1;
    release dut.state_reg;
    #1;
    check("illegal_forced", {4'b0, state}, 7'b0000111);
    expect_at(mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0), cyc + 1);
    repeat (5) @(negedge clk);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drained: got %0d pending events required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
